sb_1237_uart_msg_rx: RTL and testbench

//  Receive side of the bot's UART message link: deserialises 8N1 bytes on rx, frames them into
//  '#'-terminated ASCII messages (e.g. "GBI2-W-PICK-#") and presents each complete message

---
 rtl/sb_1237_uart_pkg.sv | 25 ++
 rtl/sb_1237_uart_rx_byte.sv | 130 +++++++++++++
 rtl/sb_1237_uart_msg_rx.sv | 147 ++++++++++++++
 tb/tb_sb_1237_uart_msg_rx.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_1237_uart_pkg.sv
// Shared types and constants for the UART message receiver: baud divider helper,
// byte-level FSM state encoding, message terminator and command prefix.
package sb_1237_uart_pkg;

  // Byte receiver states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Default message terminator ('#')
  localparam logic [7:0]  TERM_CHAR_DEF = 8'h23;

  // Command prefix "GBI" that identifies messages meant for this bot
  localparam logic [23:0] PREFIX_GBI    = 24'h474249;

  // Clock cycles per bit period (integer division)
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sb_1237_uart_rx_byte.sv
// sb_1237_uart_rx_byte: 2-flop synchroniser plus 8N1 byte receiver.
// Emits a one-cycle byte_stb with the received byte when the stop bit samples high,
// or a one-cycle frame_err when it samples low (then waits in BREAK for the line to idle).
module sb_1237_uart_rx_byte
  import sb_1237_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_stb,
  output logic       frame_err,
  output logic       busy
);

  localparam int               HALF      = CLKS_PER_BIT / 2;
  localparam int               CNT_W     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             rx_s_q, rx_s_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             bit_tick;

  // Full bit period elapsed in the current state
  assign bit_tick = (clk_cnt_q == BIT_LAST);

  // Synchroniser inputs: rx into first flop, first flop into rx_s
  always_comb begin
    sync1_d = rx;
    rx_s_d  = sync1_q;
  end

  // Synchroniser register; idles high so reset does not look like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      rx_s_q  <= rx_s_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bit timing counter, bit index and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic: start is validated at mid-bit, data and stop a full bit apart
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    unique case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s_q) state_d = ST_START;
      end
      ST_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_s_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          clk_cnt_d = '0;
          state_d   = rx_s_q ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        clk_cnt_d = '0;
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Outputs: strobes fire in the stop-bit sample cycle
  always_comb begin
    byte_stb  = 1'b0;
    frame_err = 1'b0;
    busy      = 1'b0;
    if (state_q == ST_STOP && bit_tick) begin
      byte_stb  = rx_s_q;
      frame_err = !rx_s_q;
    end
    if (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP) busy = 1'b1;
  end

  assign rx_byte = shift_q;

endmodule

// File: rtl/sb_1237_uart_msg_rx.sv
// sb_1237_uart_msg_rx: frames received UART bytes into terminator-ended ASCII messages.
// The message is packed with its final character in msg[7:0]; unused upper bytes are 0.
// Oversized messages raise ovf_err and are discarded through their terminator.
// Optional macro SB_1237_RX_PREFIX_FILTER_EN: deliver only messages starting with "GBI".
module sb_1237_uart_msg_rx
  import sb_1237_uart_pkg::*;
#(
  parameter int         CLK_HZ    = 50_000_000,
  parameter int         BAUD      = 115200,
  parameter int         MAX_LEN   = 16,
  parameter logic [7:0] TERM_CHAR = TERM_CHAR_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [8*MAX_LEN-1:0] msg,
  output logic [7:0]           msg_len,
  output logic                 msg_valid,
  output logic                 frame_err,
  output logic                 ovf_err,
  output logic                 busy
);

  localparam int         CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int         MSG_W        = 8 * MAX_LEN;
  localparam logic [7:0] LEN_MAX      = 8'(MAX_LEN);

  logic [7:0]       rx_byte;
  logic             byte_stb;
  logic             byte_ferr;
  logic             rx_busy;

  logic [MSG_W-1:0] frame_buf_q, frame_buf_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             discard_q, discard_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [7:0]       msg_len_q, msg_len_d;
  logic             msg_valid_q, msg_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             ovf_err_q, ovf_err_d;

  logic [MSG_W-1:0] shifted;
  logic [7:0]       cnt_inc;
  logic             deliver;

  sb_1237_uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_byte (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .byte_stb  (byte_stb),
    .frame_err (byte_ferr),
    .busy      (rx_busy)
  );

  // Candidate buffer with the incoming byte appended, and whether it may be delivered
  always_comb begin
    shifted = {frame_buf_q[MSG_W-9:0], rx_byte};
    cnt_inc = cnt_q + 8'd1;
`ifdef SB_1237_RX_PREFIX_FILTER_EN
    begin
      logic [23:0] head;
      head    = '0;
      deliver = 1'b0;
      if (cnt_inc >= 8'd3) begin
        // First three characters sit at the top of the occupied byte range
        head    = 24'(shifted >> (8 * (int'(cnt_inc) - 3)));
        deliver = (head == PREFIX_GBI);
      end
    end
`else
    deliver = 1'b1;
`endif
  end

  // Framer: append, terminate, overflow and discard handling
  always_comb begin
    frame_buf_d = frame_buf_q;
    cnt_d       = cnt_q;
    discard_d   = discard_q;
    msg_d       = msg_q;
    msg_len_d   = msg_len_q;
    msg_valid_d = 1'b0;
    frame_err_d = 1'b0;
    ovf_err_d   = 1'b0;
    if (byte_ferr) begin
      // A broken byte loses the partial message; last good msg is kept
      frame_err_d = 1'b1;
      frame_buf_d = '0;
      cnt_d       = '0;
    end else if (byte_stb) begin
      if (discard_q) begin
        if (rx_byte == TERM_CHAR) discard_d = 1'b0;
      end else if (rx_byte == TERM_CHAR) begin
        frame_buf_d = '0;
        cnt_d       = '0;
        if (deliver) begin
          msg_d       = shifted;
          msg_len_d   = cnt_inc;
          msg_valid_d = 1'b1;
        end
      end else if (cnt_inc == LEN_MAX) begin
        // Buffer full with no terminator: drop through the next terminator
        ovf_err_d   = 1'b1;
        frame_buf_d = '0;
        cnt_d       = '0;
        discard_d   = 1'b1;
      end else begin
        frame_buf_d = shifted;
        cnt_d       = cnt_inc;
      end
    end
  end

  // Framer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_buf_q <= '0;
      cnt_q       <= '0;
      discard_q   <= 1'b0;
      msg_q       <= '0;
      msg_len_q   <= '0;
      msg_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      frame_buf_q <= frame_buf_d;
      cnt_q       <= cnt_d;
      discard_q   <= discard_d;
      msg_q       <= msg_d;
      msg_len_q   <= msg_len_d;
      msg_valid_q <= msg_valid_d;
      frame_err_q <= frame_err_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  assign msg       = msg_q;
  assign msg_len   = msg_len_q;
  assign msg_valid = msg_valid_q;
  assign frame_err = frame_err_q;
  assign ovf_err   = ovf_err_q;
  assign busy      = rx_busy;

endmodule

// File: tb/tb_sb_1237_uart_msg_rx.sv
// Testbench for sb_1237_uart_msg_rx. A fast baud rate keeps the run short; all timing
// expectations scale with the bench's own CPB. The reference model frames bytes with a
// byte queue and also follows SB_1237_RX_PREFIX_FILTER_EN when defined.
module tb_sb_1237_uart_msg_rx;

  localparam int         CLK_HZ  = 50_000_000;
  localparam int         BAUD    = 2_500_000;
  localparam int         MAX_LEN = 16;
  localparam int         CPB     = CLK_HZ / BAUD;
  localparam int         HALF    = CPB / 2;
  localparam int         MSG_W   = 8 * MAX_LEN;
  localparam int         LAT_LO  = HALF;
  localparam int         LAT_HI  = HALF + 6;
  localparam logic [7:0] TERM    = 8'h23;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rx  = 1'b1;
  logic [MSG_W-1:0] msg;
  logic [7:0]       msg_len;
  logic             msg_valid, frame_err, ovf_err, busy;

  int cyc = 0;
  int tests = 0, fails = 0;
  int got_ferr = 0, got_ovf = 0, exp_ferr = 0, exp_ovf = 0;

  typedef struct {
    logic [MSG_W-1:0] m;
    logic [7:0]       len;
    int               cyc;
  } ev_t;

  ev_t              got_q[$];
  ev_t              exp_q[$];
  logic [7:0]       mbuf[$];
  bit               mdisc = 1'b0;
  logic [MSG_W-1:0] last_m = '0;
  logic [7:0]       last_len = '0;

  sb_1237_uart_msg_rx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .MAX_LEN   (MAX_LEN),
    .TERM_CHAR (TERM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .msg       (msg),
    .msg_len   (msg_len),
    .msg_valid (msg_valid),
    .frame_err (frame_err),
    .ovf_err   (ovf_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe DUT pulses away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (msg_valid) got_q.push_back('{m: msg, len: msg_len, cyc: cyc});
      if (frame_err) got_ferr++;
      if (ovf_err)   got_ovf++;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Reference model: one received byte (ok = stop bit high)
  task automatic model_byte(input logic [7:0] b, input bit ok, input int stop_cyc);
    logic [MSG_W-1:0] p;
    bit               dlv;
    if (!ok) begin
      exp_ferr++;
      mbuf.delete();
    end else if (mdisc) begin
      if (b == TERM) mdisc = 1'b0;
    end else begin
      mbuf.push_back(b);
      if (b == TERM) begin
        dlv = 1'b1;
`ifdef SB_1237_RX_PREFIX_FILTER_EN
        dlv = (mbuf.size() >= 3) && (mbuf[0] == 8'h47) && (mbuf[1] == 8'h42) && (mbuf[2] == 8'h49);
`endif
        if (dlv) begin
          p = '0;
          foreach (mbuf[k]) p = (p << 8) | MSG_W'(mbuf[k]);
          exp_q.push_back('{m: p, len: 8'(mbuf.size()), cyc: stop_cyc});
          last_m   = p;
          last_len = 8'(mbuf.size());
        end
        mbuf.delete();
      end else if (mbuf.size() == MAX_LEN) begin
        exp_ovf++;
        mbuf.delete();
        mdisc = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    mbuf.delete();
    mdisc    = 1'b0;
    last_m   = '0;
    last_len = '0;
  endtask

  // Drive one 8N1 frame; a bad stop bit holds the line low for 3 bit times
  task automatic send_byte(input logic [7:0] b, input bit ok);
    int stop_cyc;
    @(negedge clk) rx = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rx = b[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk) begin
      rx       = ok;
      stop_cyc = cyc;
    end
    if (ok) begin
      repeat (CPB - 1) @(negedge clk);
    end else begin
      repeat (3 * CPB - 1) @(negedge clk);
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
    model_byte(b, ok, stop_cyc);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic idle_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if (msg !== '0 || msg_len !== 8'd0) begin
      fails++;
      $display("FAIL reset_msg got len=%0d msg=%h required 0/0", msg_len, msg);
    end
    tests++;
    if ({msg_valid, frame_err, ovf_err, busy} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags got v/f/o/b=%b required 0000", {msg_valid, frame_err, ovf_err, busy});
    end
    rst = 1'b0;
    idle_bits(2);
  endtask

  task automatic test_message();
    int gb, eb;
    logic [MSG_W-1:0] want;
    gb = got_q.size();
    eb = exp_q.size();
    send_str("GBI2-W-PICK-#");
    idle_bits(2);
    tests++;
    if (got_q.size() - gb != exp_q.size() - eb) begin
      fails++;
      $display("FAIL message_count got %0d required %0d", got_q.size() - gb, exp_q.size() - eb);
    end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      tests++;
      if (got_q[gb+i].m !== exp_q[eb+i].m || got_q[gb+i].len !== exp_q[eb+i].len) begin
        fails++;
        $display("FAIL message_data got len=%0d msg=%h required len=%0d msg=%h",
                 got_q[gb+i].len, got_q[gb+i].m, exp_q[eb+i].len, exp_q[eb+i].m);
      end
      tests++;
      if (got_q[gb+i].cyc - exp_q[eb+i].cyc < LAT_LO || got_q[gb+i].cyc - exp_q[eb+i].cyc > LAT_HI) begin
        fails++;
        $display("FAIL message_latency got %0d cycles after stop edge required %0d..%0d",
                 got_q[gb+i].cyc - exp_q[eb+i].cyc, LAT_LO, LAT_HI);
      end
    end
    want = "GBI2-W-PICK-#";
    tests++;
    if (msg_len !== 8'd13 || msg !== want) begin
      fails++;
      $display("FAIL message_literal got len=%0d msg=%h required len=13 msg=%h", msg_len, msg, want);
    end
  endtask

  task automatic test_lone_and_glitch();
    int gb, eb, fb;
    gb = got_q.size();
    eb = exp_q.size();
    fb = got_ferr;
    send_str("#");
    idle_bits(2);
    tests++;
    if (got_q.size() - gb != exp_q.size() - eb) begin
      fails++;
      $display("FAIL lone_count got %0d required %0d", got_q.size() - gb, exp_q.size() - eb);
    end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      tests++;
      if (got_q[gb+i].m !== exp_q[eb+i].m || got_q[gb+i].len !== exp_q[eb+i].len) begin
        fails++;
        $display("FAIL lone_data got len=%0d msg=%h required len=%0d msg=%h",
                 got_q[gb+i].len, got_q[gb+i].m, exp_q[eb+i].len, exp_q[eb+i].m);
      end
    end
    // 0.3 bit low glitch
    gb = got_q.size();
    @(negedge clk) rx = 1'b0;
    repeat (CPB * 3 / 10) @(negedge clk);
    rx = 1'b1;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL glitch_busy_high got %b required 1", busy);
    end
    idle_bits(3);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL glitch_busy_low got %b required 0", busy);
    end
    tests++;
    if (got_q.size() != gb || got_ferr != fb) begin
      fails++;
      $display("FAIL glitch_output got %0d msgs %0d ferr required 0 0", got_q.size() - gb, got_ferr - fb);
    end
    tests++;
    if (msg !== last_m || msg_len !== last_len) begin
      fails++;
      $display("FAIL glitch_hold got len=%0d msg=%h required len=%0d msg=%h", msg_len, msg, last_len, last_m);
    end
  endtask

  task automatic test_frame_err();
    int gb, eb, fb, fe;
    gb = got_q.size();
    eb = exp_q.size();
    fb = got_ferr;
    fe = exp_ferr;
    send_byte(8'h41, 1'b0);
    tests++;
    if (msg !== last_m || msg_len !== last_len) begin
      fails++;
      $display("FAIL ferr_hold got len=%0d msg=%h required len=%0d msg=%h", msg_len, msg, last_len, last_m);
    end
    send_str("AB#");
    idle_bits(2);
    tests++;
    if (got_ferr - fb != exp_ferr - fe) begin
      fails++;
      $display("FAIL ferr_count got %0d required %0d", got_ferr - fb, exp_ferr - fe);
    end
    tests++;
    if (got_q.size() - gb != exp_q.size() - eb) begin
      fails++;
      $display("FAIL ferr_msg_count got %0d required %0d", got_q.size() - gb, exp_q.size() - eb);
    end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      tests++;
      if (got_q[gb+i].m !== exp_q[eb+i].m || got_q[gb+i].len !== exp_q[eb+i].len) begin
        fails++;
        $display("FAIL ferr_msg_data got len=%0d msg=%h required len=%0d msg=%h",
                 got_q[gb+i].len, got_q[gb+i].m, exp_q[eb+i].len, exp_q[eb+i].m);
      end
    end
  endtask

  task automatic test_overflow();
    int gb, eb, ob, oe;
    gb = got_q.size();
    eb = exp_q.size();
    ob = got_ovf;
    oe = exp_ovf;
    for (int i = 0; i < 15; i++) send_byte(8'h41, 1'b1);
    tests++;
    if (got_ovf != ob) begin
      fails++;
      $display("FAIL ovf_early got %0d pulses required 0", got_ovf - ob);
    end
    send_byte(8'h41, 1'b1);
    tests++;
    if (got_ovf - ob != exp_ovf - oe) begin
      fails++;
      $display("FAIL ovf_16th got %0d pulses required %0d", got_ovf - ob, exp_ovf - oe);
    end
    send_byte(8'h41, 1'b1);
    send_str("XY#");
    tests++;
    if (got_q.size() != gb || got_ovf - ob != exp_ovf - oe) begin
      fails++;
      $display("FAIL ovf_discard got %0d msgs %0d ovf required 0 msgs %0d ovf",
               got_q.size() - gb, got_ovf - ob, exp_ovf - oe);
    end
    send_str("Q#");
    idle_bits(2);
    tests++;
    if (got_q.size() - gb != exp_q.size() - eb) begin
      fails++;
      $display("FAIL ovf_resume_count got %0d required %0d", got_q.size() - gb, exp_q.size() - eb);
    end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      tests++;
      if (got_q[gb+i].m !== exp_q[eb+i].m || got_q[gb+i].len !== exp_q[eb+i].len) begin
        fails++;
        $display("FAIL ovf_resume_data got len=%0d msg=%h required len=%0d msg=%h",
                 got_q[gb+i].len, got_q[gb+i].m, exp_q[eb+i].len, exp_q[eb+i].m);
      end
    end
  endtask

  task automatic test_max_len();
    int gb, eb, ob, oe;
    gb = got_q.size();
    eb = exp_q.size();
    ob = got_ovf;
    oe = exp_ovf;
    for (int i = 0; i < MAX_LEN - 1; i++) send_byte(8'h41, 1'b1);
    send_byte(TERM, 1'b1);
    idle_bits(2);
    tests++;
    if (got_q.size() - gb != exp_q.size() - eb || got_ovf - ob != exp_ovf - oe) begin
      fails++;
      $display("FAIL maxlen_count got %0d msgs %0d ovf required %0d msgs %0d ovf",
               got_q.size() - gb, got_ovf - ob, exp_q.size() - eb, exp_ovf - oe);
    end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      tests++;
      if (got_q[gb+i].m !== exp_q[eb+i].m || got_q[gb+i].len !== exp_q[eb+i].len) begin
        fails++;
        $display("FAIL maxlen_data got len=%0d msg=%h required len=%0d msg=%h",
                 got_q[gb+i].len, got_q[gb+i].m, exp_q[eb+i].len, exp_q[eb+i].m);
      end
    end
`ifndef SB_1237_RX_PREFIX_FILTER_EN
    tests++;
    if (msg_len !== 8'd16 || msg[7:0] !== 8'h23 || msg[127:120] !== 8'h41) begin
      fails++;
      $display("FAIL maxlen_literal got len=%0d low=%h high=%h required 16 23 41",
               msg_len, msg[7:0], msg[127:120]);
    end
`endif
  endtask

  task automatic test_rst_mid();
    int gb, eb;
    logic [7:0] b;
    b = 8'h49;
    send_str("GB");
    @(negedge clk) rx = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) rx = b[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk) rx = b[4];
    repeat (HALF) @(negedge clk);
    rx  = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    tests++;
    if (msg !== '0 || msg_len !== 8'd0 || {msg_valid, frame_err, ovf_err, busy} !== 4'b0000) begin
      fails++;
      $display("FAIL rst_mid_outputs got len=%0d msg=%h flags=%b required all 0",
               msg_len, msg, {msg_valid, frame_err, ovf_err, busy});
    end
    rst = 1'b0;
    idle_bits(2);
    gb = got_q.size();
    eb = exp_q.size();
    send_str("OK#");
    send_str("GBI#");
    idle_bits(2);
    tests++;
    if (got_q.size() - gb != exp_q.size() - eb) begin
      fails++;
      $display("FAIL rst_mid_count got %0d required %0d", got_q.size() - gb, exp_q.size() - eb);
    end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      tests++;
      if (got_q[gb+i].m !== exp_q[eb+i].m || got_q[gb+i].len !== exp_q[eb+i].len) begin
        fails++;
        $display("FAIL rst_mid_data got len=%0d msg=%h required len=%0d msg=%h",
                 got_q[gb+i].len, got_q[gb+i].m, exp_q[eb+i].len, exp_q[eb+i].m);
      end
    end
  endtask

  task automatic test_random();
    int gb, eb, fb, fe, ob, oe;
    int len;
    bit pre;
    logic [7:0] ch;
    gb = got_q.size();
    eb = exp_q.size();
    fb = got_ferr;
    fe = exp_ferr;
    ob = got_ovf;
    oe = exp_ovf;
    for (int n = 0; n < 12; n++) begin
      len = $urandom_range(1, 19);
      pre = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        if (k == len - 1)       ch = TERM;
        else if (pre && k == 0) ch = 8'h47;
        else if (pre && k == 1) ch = 8'h42;
        else if (pre && k == 2) ch = 8'h49;
        else                    ch = 8'($urandom_range(8'h41, 8'h5A));
        send_byte(ch, $urandom_range(0, 24) != 0);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2 * CPB)) @(negedge clk);
      end
    end
    idle_bits(2);
    tests++;
    if (got_ferr - fb != exp_ferr - fe || got_ovf - ob != exp_ovf - oe) begin
      fails++;
      $display("FAIL random_errs got ferr=%0d ovf=%0d required ferr=%0d ovf=%0d",
               got_ferr - fb, got_ovf - ob, exp_ferr - fe, exp_ovf - oe);
    end
    tests++;
    if (got_q.size() - gb != exp_q.size() - eb) begin
      fails++;
      $display("FAIL random_count got %0d required %0d", got_q.size() - gb, exp_q.size() - eb);
    end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      tests++;
      if (got_q[gb+i].m !== exp_q[eb+i].m || got_q[gb+i].len !== exp_q[eb+i].len) begin
        fails++;
        $display("FAIL random_data[%0d] got len=%0d msg=%h required len=%0d msg=%h",
                 i, got_q[gb+i].len, got_q[gb+i].m, exp_q[eb+i].len, exp_q[eb+i].m);
      end
      tests++;
      if (got_q[gb+i].cyc - exp_q[eb+i].cyc < LAT_LO || got_q[gb+i].cyc - exp_q[eb+i].cyc > LAT_HI) begin
        fails++;
        $display("FAIL random_latency[%0d] got %0d required %0d..%0d",
                 i, got_q[gb+i].cyc - exp_q[eb+i].cyc, LAT_LO, LAT_HI);
      end
    end
    tests++;
    if (msg !== last_m || msg_len !== last_len) begin
      fails++;
      $display("FAIL random_hold got len=%0d msg=%h required len=%0d msg=%h", msg_len, msg, last_len, last_m);
    end
  endtask

  initial begin
    test_reset();
    test_message();
    test_lone_and_glitch();
    test_frame_err();
    test_overflow();
    test_max_len();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
